// File: rtl/wb_pipe_reg_chain_pkg.sv
// Shared constants and helpers for the write-back pipeline register chain.
package wb_pipe_reg_chain_pkg;

    localparam int unsigned MaxStages = 8;

    // Smallest occupancy width able to represent 0..stages.
    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

    function automatic logic [3:0] count_ones(input logic [MaxStages-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MaxStages; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/wb_pipe_reg_chain_if.sv
// Valid/ready bus between upstream producer, the register chain and downstream write-back.
interface wb_pipe_reg_chain_if #(
    parameter int unsigned NrOfBits = 32
);
    logic                in_valid;
    logic [NrOfBits-1:0] in_data;
    logic                in_ready;
    logic                out_valid;
    logic [NrOfBits-1:0] out_data;
    logic                out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/wb_pipe_reg_chain_stage.sv
// One elastic stage: data+valid register with flush, preset and handshake load/hold.
module wb_pipe_reg_chain_stage #(
    parameter int unsigned          NrOfBits    = 32,
    parameter bit                   IsLast      = 1'b0,
    parameter logic [NrOfBits-1:0]  PresetValue = '0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                adv,
    input  logic                canload,
    input  logic                flush,
    input  logic                pre,
    input  logic                src_valid,
    input  logic [NrOfBits-1:0] src_data,
    output logic                valid,
    output logic                valid_next,
    output logic [NrOfBits-1:0] data
);

    logic                valid_q, valid_d;
    logic [NrOfBits-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (pre) begin
            valid_d = IsLast;
            if (IsLast) data_d = PresetValue;
        end else if (adv && canload) begin
            // A bubble from the source still frees this stage; data only moves when valid.
            valid_d = src_valid;
            if (src_valid) data_d = src_data;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid      = valid_q;
    assign valid_next = valid_d;
    assign data       = data_q;

endmodule

// File: rtl/wb_pipe_reg_chain.sv
// Elastic write-back register chain with tick qualification, flush, preset, output mask
// and registered occupancy count.
module wb_pipe_reg_chain
    import wb_pipe_reg_chain_pkg::*;
#(
    parameter int unsigned         NrOfBits    = 32,
    parameter int unsigned         NrOfStages  = 2,
    parameter logic [NrOfBits-1:0] PresetValue = '0,
    parameter int unsigned         CountBits   = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ClockEnable,
    input  logic                  Tick,
    input  logic                  flush,
    input  logic                  pre,
    input  logic                  cs,
    wb_pipe_reg_chain_if.slave    bus,
    output logic [CountBits-1:0]  occupancy
);

    logic                                 adv, pop;
    logic [NrOfStages-1:0]                valid_q, valid_d;
    logic [NrOfStages-1:0][NrOfBits-1:0]  data_q;
    logic [NrOfStages:0]                  canload;
    logic [MaxStages-1:0]                 valid_ext;
    logic [CountBits-1:0]                 occ_q;

    assign adv = ClockEnable & Tick;
    assign pop = adv & bus.out_valid & bus.out_ready;

    // Ready ripples from the output end: a stage frees up if empty or its successor frees up.
    always_comb begin
        canload             = '0;
        canload[NrOfStages] = pop;
        for (int k = NrOfStages - 1; k >= 0; k--) begin
            canload[k] = ~valid_q[k] | canload[k+1];
        end
    end

    assign bus.in_ready  = adv & canload[0] & ~flush & ~pre;
    assign bus.out_valid = valid_q[NrOfStages-1] & ~cs;
    assign bus.out_data  = cs ? '0 : data_q[NrOfStages-1];

    for (genvar k = 0; k < NrOfStages; k++) begin : g_stage
        logic                src_valid;
        logic [NrOfBits-1:0] src_data;

        if (k == 0) begin : g_head
            assign src_valid = bus.in_valid;
            assign src_data  = bus.in_data;
        end else begin : g_body
            assign src_valid = valid_q[k-1];
            assign src_data  = data_q[k-1];
        end

        wb_pipe_reg_chain_stage #(
            .NrOfBits    (NrOfBits),
            .IsLast      (k == NrOfStages - 1),
            .PresetValue (PresetValue)
        ) u_stage (
            .Clock      (Clock),
            .Reset      (Reset),
            .adv        (adv),
            .canload    (canload[k]),
            .flush      (flush),
            .pre        (pre),
            .src_valid  (src_valid),
            .src_data   (src_data),
            .valid      (valid_q[k]),
            .valid_next (valid_d[k]),
            .data       (data_q[k])
        );
    end

    always_comb begin
        valid_ext                 = '0;
        valid_ext[NrOfStages-1:0] = valid_d;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= CountBits'(count_ones(valid_ext));
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_wb_pipe_reg_chain.sv
// Directed self-checking bench for wb_pipe_reg_chain (2 stages, 32-bit, all-ones preset).
module tb_wb_pipe_reg_chain;

    logic        Clock;
    logic        Reset;
    logic        ClockEnable;
    logic        Tick;
    logic        flush;
    logic        pre;
    logic        cs;
    logic [3:0]  occupancy;
    int          total;
    int          bad;

    wb_pipe_reg_chain_if #(.NrOfBits(32)) bus ();

    wb_pipe_reg_chain #(
        .NrOfBits    (32),
        .NrOfStages  (2),
        .PresetValue (32'hFFFF_FFFF),
        .CountBits   (4)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ClockEnable (ClockEnable),
        .Tick        (Tick),
        .flush       (flush),
        .pre         (pre),
        .cs          (cs),
        .bus         (bus),
        .occupancy   (occupancy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle;
        ClockEnable   = 1'b1;
        Tick          = 1'b1;
        flush         = 1'b0;
        pre           = 1'b0;
        cs            = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        Reset = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        @(negedge Clock);
        Reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h5A;
        step();
        bus.in_data  = 32'h5B;
        step();
        bus.in_valid = 1'b0;
        total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL rst_fill_occ: got %0d want 2", occupancy); end
        total++; if (bus.out_data !== 32'h5A) begin bad++; $display("FAIL rst_fill_data: got %h want 5a", bus.out_data); end
        #2;
        Reset = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL rst_mid_occ: got %0d want 0", occupancy); end
        total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL rst_mid_data: got %h want 0", bus.out_data); end
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_stream;
        logic [31:0] exp_out [3];
        exp_out[0] = 32'h11; exp_out[1] = 32'h22; exp_out[2] = 32'h33;
        idle();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h11;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_latency: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready0: got %b want 1", bus.in_ready); end
        bus.in_data = 32'h22;
        step();
        bus.in_data = 32'h33;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_out[i]) begin
                bad++; $display("FAIL stream_out%0d: got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, exp_out[i]);
            end
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready%0d: got %b want 1", i + 1, bus.in_ready); end
            step();
            bus.in_valid = 1'b0;
        end
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0", bus.out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure;
        idle();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hA;
        step();
        total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL bp_occ1: got %0d want 1", occupancy); end
        bus.in_data = 32'hB;
        step();
        bus.in_data = 32'hC;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL bp_occ2: got %0d want 2", occupancy); end
        step();
        total++; if (occupancy !== 4'd2 || bus.out_data !== 32'hA) begin
            bad++; $display("FAIL bp_hold: got occ=%0d d=%h want occ=2 d=a", occupancy, bus.out_data);
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB) begin
            bad++; $display("FAIL bp_out_b: got v=%b d=%h want v=1 d=b", bus.out_valid, bus.out_data);
        end
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hC) begin
            bad++; $display("FAIL bp_out_c: got v=%b d=%h want v=1 d=c", bus.out_valid, bus.out_data);
        end
        step();
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL bp_drain: got v=%b occ=%0d want v=0 occ=0", bus.out_valid, occupancy);
        end
    endtask

    task automatic test_tick;
        idle();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h55;
        for (int p = 0; p < 3; p++) begin
            Tick = 1'b0;
            for (int i = 0; i < 3; i++) begin
                #1;
                if (p == 0) begin
                    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL tick_ready_low%0d: got %b want 0", i, bus.in_ready); end
                end
                step();
                total++; if (occupancy !== ((p == 0) ? 4'd0 : (p == 1) ? 4'd1 : 4'd1)) begin
                    bad++; $display("FAIL tick_occ_p%0d_%0d: got %0d", p, i, occupancy);
                end
                if (p == 2) begin
                    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55) begin
                        bad++; $display("FAIL tick_stable%0d: got v=%b d=%h want v=1 d=55", i, bus.out_valid, bus.out_data);
                    end
                end
            end
            Tick = 1'b1;
            step();
            bus.in_valid = 1'b0;
            if (p == 0) begin
                total++; if (occupancy !== 4'd1 || bus.out_valid !== 1'b0) begin
                    bad++; $display("FAIL tick_accept: got occ=%0d v=%b want occ=1 v=0", occupancy, bus.out_valid);
                end
            end else if (p == 1) begin
                total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55) begin
                    bad++; $display("FAIL tick_out: got v=%b d=%h want v=1 d=55", bus.out_valid, bus.out_data);
                end
            end else begin
                total++; if (bus.out_valid !== 1'b0 || occupancy !== 4'd0) begin
                    bad++; $display("FAIL tick_pop: got v=%b occ=%0d want v=0 occ=0", bus.out_valid, occupancy);
                end
            end
        end
    endtask

    task automatic test_flush_pre;
        idle();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1;
        step();
        bus.in_data = 32'h2;
        step();
        total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL fp_full: got %0d want 2", occupancy); end
        bus.in_data = 32'h3;
        flush = 1'b1;
        pre   = 1'b1;
        Tick  = 1'b0;
        bus.out_ready = 1'b1;
        Tick  = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fp_in_ready: got %b want 0", bus.in_ready); end
        Tick = 1'b0;
        step();
        total++; if (occupancy !== 4'd0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL fp_flush_wins: got occ=%0d v=%b want occ=0 v=0", occupancy, bus.out_valid);
        end
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        pre = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFF || occupancy !== 4'd1) begin
            bad++; $display("FAIL fp_preset: got v=%b d=%h occ=%0d want v=1 d=ffffffff occ=1", bus.out_valid, bus.out_data, occupancy);
        end
        Tick = 1'b1;
        bus.out_ready = 1'b1;
        step();
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL fp_drain: got v=%b occ=%0d want v=0 occ=0", bus.out_valid, occupancy);
        end
    endtask

    task automatic test_cs;
        idle();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        step();
        bus.in_data = 32'h88;
        step();
        bus.in_valid  = 1'b0;
        cs            = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            bad++; $display("FAIL cs_mask: got v=%b d=%h want v=0 d=0", bus.out_valid, bus.out_data);
        end
        step();
        total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL cs_no_pop: got %0d want 2", occupancy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL cs_bp: got %b want 0", bus.in_ready); end
        cs = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h77) begin
            bad++; $display("FAIL cs_unmask: got v=%b d=%h want v=1 d=77", bus.out_valid, bus.out_data);
        end
        test_back_to_back();
    endtask

    // Full chain, push and pop on the same edge.
    task automatic test_back_to_back;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h99;
        step();
        bus.in_valid = 1'b0;
        total++; if (occupancy !== 4'd2 || bus.out_data !== 32'h88) begin
            bad++; $display("FAIL b2b_push_pop: got occ=%0d d=%h want occ=2 d=88", occupancy, bus.out_data);
        end
        step();
        total++; if (bus.out_data !== 32'h99 || occupancy !== 4'd1) begin
            bad++; $display("FAIL b2b_next: got occ=%0d d=%h want occ=1 d=99", occupancy, bus.out_data);
        end
        step();
        total++; if (bus.out_valid !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL b2b_drain: got v=%b occ=%0d want v=0 occ=0", bus.out_valid, occupancy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_tick();
        test_flush_pre();
        test_cs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
